pc_sequencer: RTL and testbench

Control FSM that sequences the 10-bit program counter of the RAT MCU. It drives the PC mux select, PC load/increment, stack-pointer and scratch-RAM strobes, and owns the interrupt-enable flag plus the pending-interrupt latch. It sits between the instruction decoder, which supplies a decoded flow class and the branch condition, and the PC/SP/scratch-RAM datapath.

---
 rtl/rat_pkg.sv | 28 ++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT MCU control path.
package rat_pkg;

    typedef enum logic [2:0] {
        OP_OTHER = 3'd0,
        OP_BRN   = 3'd1,
        OP_BRCC  = 3'd2,
        OP_CALL  = 3'd3,
        OP_RET   = 3'd4,
        OP_RETI  = 3'd5,
        OP_SEI   = 3'd6,
        OP_CLI   = 3'd7
    } op_class_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_INTR  = 2'd3
    } state_t;

    localparam logic [1:0] PCMUX_IR  = 2'd0;
    localparam logic [1:0] PCMUX_SCR = 2'd1;
    localparam logic [1:0] PCMUX_VEC = 2'd2;

    localparam logic [9:0] INTR_VECTOR = 10'h3FF;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencing FSM: fetch/execute/interrupt control with
// interrupt-enable flag and pending-interrupt latch.
module pc_sequencer
    import rat_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] OP_CLASS,
    input  logic       COND_TRUE,
    input  logic       INTR,
    output logic       PC_RST,
    output logic       PC_LD,
    output logic       PC_INC,
    output logic [1:0] PC_MUX_SEL,
    output logic       IR_LD,
    output logic       SCR_WE,
    output logic       SP_DECR,
    output logic       SP_INCR,
    output logic       FLG_SAVE,
    output logic       FLG_RESTORE,
    output logic       INTR_ACK,
    output logic       I_FLAG
);

    state_t    state_q, state_d;
    logic      i_flag_q, i_flag_d;
    logic      pend_q, pend_d;
    op_class_t op;

    always_comb begin
        op          = op_class_t'(OP_CLASS);
        state_d     = state_q;
        i_flag_d    = i_flag_q;
        pend_d      = pend_q | INTR;
        PC_RST      = 1'b0;
        PC_LD       = 1'b0;
        PC_INC      = 1'b0;
        PC_MUX_SEL  = PCMUX_IR;
        IR_LD       = 1'b0;
        SCR_WE      = 1'b0;
        SP_DECR     = 1'b0;
        SP_INCR     = 1'b0;
        FLG_SAVE    = 1'b0;
        FLG_RESTORE = 1'b0;
        INTR_ACK    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                PC_RST  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                IR_LD   = 1'b1;
                PC_INC  = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (op)
                    OP_BRN: PC_LD = 1'b1;
                    OP_BRCC: PC_LD = COND_TRUE;
                    OP_CALL: begin
                        PC_LD   = 1'b1;
                        SCR_WE  = 1'b1;
                        SP_DECR = 1'b1;
                    end
                    OP_RET: begin
                        PC_LD      = 1'b1;
                        PC_MUX_SEL = PCMUX_SCR;
                        SP_INCR    = 1'b1;
                    end
                    OP_RETI: begin
                        PC_LD       = 1'b1;
                        PC_MUX_SEL  = PCMUX_SCR;
                        SP_INCR     = 1'b1;
                        FLG_RESTORE = 1'b1;
                        i_flag_d    = 1'b1;
                    end
                    OP_SEI:   i_flag_d = 1'b1;
                    OP_CLI:   i_flag_d = 1'b0;
                    OP_OTHER: ;
                endcase
                // Uses the post-update flag so SEI/RETI open and CLI closes the window now
                state_d = (pend_q && i_flag_d) ? ST_INTR : ST_FETCH;
            end
            ST_INTR: begin
                PC_LD      = 1'b1;
                PC_MUX_SEL = PCMUX_VEC;
                SCR_WE     = 1'b1;
                SP_DECR    = 1'b1;
                FLG_SAVE   = 1'b1;
                INTR_ACK   = 1'b1;
                i_flag_d   = 1'b0;
                pend_d     = 1'b0;
                state_d    = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_INIT;
            i_flag_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_flag_q <= i_flag_d;
            pend_q   <= pend_d;
        end
    end

    assign I_FLAG = i_flag_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts every cycle's outputs.
module tb_pc_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [2:0] OP_CLASS = '0;
    logic       COND_TRUE = 1'b0;
    logic       INTR = 1'b0;
    logic       PC_RST, PC_LD, PC_INC, IR_LD, SCR_WE, SP_DECR, SP_INCR;
    logic       FLG_SAVE, FLG_RESTORE, INTR_ACK, I_FLAG;
    logic [1:0] PC_MUX_SEL;

    pc_sequencer dut (
        .CLK(CLK), .RST(RST), .OP_CLASS(OP_CLASS), .COND_TRUE(COND_TRUE), .INTR(INTR),
        .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC), .PC_MUX_SEL(PC_MUX_SEL),
        .IR_LD(IR_LD), .SCR_WE(SCR_WE), .SP_DECR(SP_DECR), .SP_INCR(SP_INCR),
        .FLG_SAVE(FLG_SAVE), .FLG_RESTORE(FLG_RESTORE), .INTR_ACK(INTR_ACK), .I_FLAG(I_FLAG)
    );

    always #5 CLK = ~CLK;

    localparam logic [2:0] OTHER = 3'd0, BRN = 3'd1, BRCC = 3'd2, CALL = 3'd3;
    localparam logic [2:0] RET = 3'd4, RETI = 3'd5, SEI = 3'd6, CLI = 3'd7;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned acks   = 0;

    // Model state: 0 INIT, 1 FETCH, 2 EXEC, 3 INTR
    int   m_state = 0;
    bit   m_if = 0, m_pend = 0, m_known = 0;
    logic intr_lvl = 1'b0;
    logic [12:0] sb[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // {PC_RST, PC_LD, PC_INC, MUX[1:0], IR_LD, SCR_WE, SP_DECR, SP_INCR, FLG_SAVE, FLG_RESTORE, INTR_ACK, I_FLAG}
    function automatic logic [12:0] model_out(input logic [2:0] op, input logic cond);
        logic [12:0] e;
        e = '0;
        case (m_state)
            0: e[12] = 1'b1;
            1: begin e[10] = 1'b1; e[7] = 1'b1; end
            2: case (op)
                BRN:  e[11] = 1'b1;
                BRCC: e[11] = cond;
                CALL: begin e[11] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; end
                RET:  begin e[11] = 1'b1; e[9:8] = 2'd1; e[4] = 1'b1; end
                RETI: begin e[11] = 1'b1; e[9:8] = 2'd1; e[4] = 1'b1; e[2] = 1'b1; end
                default: ;
            endcase
            default: begin
                e[11] = 1'b1; e[9:8] = 2'd2; e[6] = 1'b1; e[5] = 1'b1;
                e[3] = 1'b1; e[1] = 1'b1;
            end
        endcase
        e[0] = m_if;
        return e;
    endfunction

    task automatic model_tick(input logic rst, input logic [2:0] op, input logic intr);
        bit new_if;
        int nxt;
        if (rst) begin
            m_state = 0; m_if = 0; m_pend = 0; m_known = 1;
        end else if (m_known) begin
            case (m_state)
                0: begin m_pend = m_pend | intr; m_state = 1; end
                1: begin m_pend = m_pend | intr; m_state = 2; end
                2: begin
                    new_if = (op == SEI || op == RETI) ? 1'b1 : (op == CLI) ? 1'b0 : m_if;
                    nxt = (m_pend && new_if) ? 3 : 1;
                    m_pend = m_pend | intr;
                    m_if = new_if;
                    m_state = nxt;
                end
                default: begin m_if = 0; m_pend = 0; m_state = 1; end
            endcase
        end
    endtask

    task automatic step(input logic rst, input logic [2:0] op, input logic cond, input string tag);
        logic [12:0] e, a;
        logic drv_intr;
        bit ex_ack;
        RST = rst; OP_CLASS = op; COND_TRUE = cond; INTR = intr_lvl;
        drv_intr = intr_lvl;
        if (m_known) sb.push_back(model_out(op, cond));
        @(negedge CLK);
        ex_ack = 0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = {PC_RST, PC_LD, PC_INC, PC_MUX_SEL, IR_LD, SCR_WE, SP_DECR, SP_INCR,
                 FLG_SAVE, FLG_RESTORE, INTR_ACK, I_FLAG};
            check(tag, {19'd0, a}, {19'd0, e});
            ex_ack = e[1];
        end
        if (INTR_ACK === 1'b1) acks++;
        @(posedge CLK);
        model_tick(rst, op, drv_intr);
        if (ex_ack) intr_lvl = 1'b0;
        #1;
    endtask

    // fi/ei: INTR level to drive in FETCH/EXEC; negative keeps the current level
    task automatic instr(input logic [2:0] op, input logic cond, input int fi, input int ei,
                         input string tag);
        if (fi >= 0) intr_lvl = (fi != 0);
        step(1'b0, op, cond, {tag, ".F"});
        if (ei >= 0) intr_lvl = (ei != 0);
        step(1'b0, op, cond, {tag, ".E"});
        if (m_state == 3) step(1'b0, OTHER, 1'b0, {tag, ".I"});
    endtask

    initial begin
        step(1'b1, OTHER, 1'b0, "rst0");
        step(1'b1, OTHER, 1'b0, "rst1");
        step(1'b0, OTHER, 1'b0, "init");

        instr(OTHER, 1'b0, 0, 0, "other");
        instr(BRCC,  1'b0, 0, 0, "brcc_nt");
        instr(BRCC,  1'b1, 0, 0, "brcc_t");
        instr(BRN,   1'b0, 0, 0, "brn");
        instr(CALL,  1'b0, 0, 0, "call");
        instr(RET,   1'b0, 0, 0, "ret");

        // Masked request latched, serviced after SEI
        instr(OTHER, 1'b0, 1, 0, "mask_pulse");
        instr(OTHER, 1'b0, 0, 0, "mask_hold");
        instr(SEI,   1'b0, 0, 0, "sei_take");

        // CLI blocks, RETI with INTR held re-opens and takes it
        instr(SEI,   1'b0, 0, 0, "sei2");
        instr(CLI,   1'b0, 1, 1, "cli_blk");
        instr(RETI,  1'b0, -1, -1, "reti_take");

        // Request arriving during SEI EXEC is taken after the next EXEC
        instr(SEI,   1'b0, 0, 1, "sei_late");
        instr(OTHER, 1'b0, -1, -1, "after_sei");

        // Reset while in INTR
        instr(SEI,   1'b0, 0, 0, "sei3");
        intr_lvl = 1'b1;
        step(1'b0, OTHER, 1'b0, "pre_rst.F");
        step(1'b0, OTHER, 1'b0, "pre_rst.E");
        step(1'b1, OTHER, 1'b0, "rst_in_intr");
        step(1'b0, OTHER, 1'b0, "rst_init");
        check("iflag_post_rst", {31'd0, I_FLAG}, 32'd0);
        instr(SEI,   1'b0, 0, 0, "sei4");
        instr(OTHER, 1'b0, 0, 0, "no_pend");

        check("ack_count", acks, 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
